// File: rtl/g709_deframer.sv
// Strips RS(255,239) parity slots from the decoder word stream and emits payload
// words with sop/eop; accumulates decoder error reports into saturating counters.
module g709_deframer #(
    parameter int unsigned pWORDS_N = 255,
    parameter int unsigned pDATA_N  = 239,
    parameter int unsigned pSTAT_W  = 32
) (
    input  logic               iclk,
    input  logic               ireset,
    input  logic               iclkena,
    input  logic               ival,
    input  logic               isop,
    input  logic [127:0]       idat,
    input  logic               idecval,
    input  logic [4:0]         idecerr,
    input  logic [7:0]         isymerr,
    input  logic [10:0]        ibiterr,
    input  logic               iclr_stat,
    output logic               oval,
    output logic               osop,
    output logic               oeop,
    output logic [127:0]       odat,
    output logic               ofrm_err,
    output logic [pSTAT_W-1:0] ofrm_cnt,
    output logic [pSTAT_W-1:0] ouncorr_cnt,
    output logic [pSTAT_W-1:0] osymerr_cnt,
    output logic [pSTAT_W-1:0] obiterr_cnt
);

    localparam int unsigned CNT_W = $clog2(pWORDS_N);
    localparam int unsigned SUM_W = ((pSTAT_W > 11) ? pSTAT_W : 11) + 1;
    localparam logic        ONE_WORD = (pDATA_N == 1);

    typedef enum logic [1:0] {HUNT, PAYLOAD, PARITY} state_t;

    state_t             state;
    logic [CNT_W-1:0]   wcnt;
    logic               eop_now;
    logic [pSTAT_W-1:0] frm_base, uncorr_base, sym_base, bit_base;

    // Sum is kept wide enough that an 11-bit increment never wraps before saturation.
    function automatic logic [pSTAT_W-1:0] sat_add(input logic [pSTAT_W-1:0] base,
                                                   input logic [10:0]        inc);
        logic [SUM_W-1:0] s;
        s = SUM_W'(base) + SUM_W'(inc);
        return (|s[SUM_W-1:pSTAT_W]) ? '1 : s[pSTAT_W-1:0];
    endfunction

    always_comb begin
        eop_now = 1'b0;
        if (ival) begin
            if (isop)
                eop_now = ONE_WORD;
            else if (state == PAYLOAD && wcnt == CNT_W'(pDATA_N - 1))
                eop_now = 1'b1;
        end
        frm_base    = iclr_stat ? '0 : ofrm_cnt;
        uncorr_base = iclr_stat ? '0 : ouncorr_cnt;
        sym_base    = iclr_stat ? '0 : osymerr_cnt;
        bit_base    = iclr_stat ? '0 : obiterr_cnt;
    end

    always_ff @(posedge iclk) begin
        if (!ireset) begin
            state    <= HUNT;
            wcnt     <= '0;
            oval     <= 1'b0;
            osop     <= 1'b0;
            oeop     <= 1'b0;
            ofrm_err <= 1'b0;
            odat     <= '0;
        end else if (iclkena) begin
            oval     <= 1'b0;
            osop     <= 1'b0;
            oeop     <= 1'b0;
            ofrm_err <= 1'b0;
            if (ival) begin
                if (isop) begin
                    // A sop outside HUNT truncates the running frame and restarts at word 0.
                    ofrm_err <= (state != HUNT);
                    oval     <= 1'b1;
                    osop     <= 1'b1;
                    oeop     <= ONE_WORD;
                    odat     <= idat;
                    wcnt     <= CNT_W'(1);
                    state    <= ONE_WORD ? PARITY : PAYLOAD;
                end else begin
                    case (state)
                        PAYLOAD: begin
                            oval <= 1'b1;
                            odat <= idat;
                            wcnt <= wcnt + CNT_W'(1);
                            if (eop_now) begin
                                oeop  <= 1'b1;
                                state <= PARITY;
                            end
                        end
                        PARITY: begin
                            if (wcnt == CNT_W'(pWORDS_N - 1)) begin
                                wcnt  <= '0;
                                state <= HUNT;
                            end else begin
                                wcnt <= wcnt + CNT_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (!ireset) begin
            ofrm_cnt    <= '0;
            ouncorr_cnt <= '0;
            osymerr_cnt <= '0;
            obiterr_cnt <= '0;
        end else if (iclkena) begin
            ofrm_cnt    <= sat_add(frm_base, {10'd0, eop_now});
            ouncorr_cnt <= idecval ? sat_add(uncorr_base, {6'd0, idecerr}) : uncorr_base;
            osymerr_cnt <= idecval ? sat_add(sym_base, {3'd0, isymerr})    : sym_base;
            obiterr_cnt <= idecval ? sat_add(bit_base, ibiterr)            : bit_base;
        end
    end

endmodule

// File: doc/g709_deframer.md
# g709_deframer

Receive-side deframer for the 16-byte interleaved G.709 RS(255,239) path. Sits directly after `g709_dec`: consumes its 128-bit word stream (255 words per frame, sop on word 0) and strips the 16 parity word slots. Emits the 239 payload words with sop/eop markers. Also accumulates the decoder's per-frame error reports into saturating statistics counters for BER monitoring.

## Interface
- pWORDS_N, 255, words per coded frame
- pDATA_N, 239, payload words per frame (pDATA_N < pWORDS_N)
- pSTAT_W, 32, width of every statistics counter
- iclk  in  1  clock, all logic on rising edge
- ireset  in  1  reset; synchronous, active-low (0 = reset)
- iclkena  in  1  clock enable; when 0 all state and outputs hold
- ival  in  1  input word valid (from decoder oval)
- isop  in  1  first word of frame, qualified by ival
- idat  in  128  input word
- idecval  in  1  decoder statistics strobe, independent of ival
- idecerr  in  5  uncorrectable codewords in the frame (0..16)
- isymerr  in  8  corrected symbols in the frame
- ibiterr  in  11  corrected bits in the frame
- iclr_stat  in  1  synchronous clear of statistics counters
- oval  out  1  payload word valid
- osop  out  1  first payload word
- oeop  out  1  last payload word (word pDATA_N-1)
- odat  out  128  payload word
- ofrm_err  out  1  one-cycle pulse: frame truncated by early sop
- ofrm_cnt  out  pSTAT_W  completed frames
- ouncorr_cnt  out  pSTAT_W  sum of idecerr
- osymerr_cnt  out  pSTAT_W  sum of isymerr
- obiterr_cnt  out  pSTAT_W  sum of ibiterr

## Operation
- States: HUNT, PAYLOAD, PARITY. Word counter wcnt is ceil(log2(pWORDS_N)) bits wide.
- All transitions and updates occur only on cycles with iclkena=1. Input words count only when ival=1. Gaps of ival=0 are allowed anywhere.
- HUNT:
  - ival & isop: forward the word as payload word 0 with osop=1, set wcnt=1, go to PAYLOAD.
  - ival & !isop: word is discarded silently.
- PAYLOAD:
  - ival & !isop: forward the word; wcnt++.
  - The word with wcnt = pDATA_N-1 is forwarded with oeop=1, increments ofrm_cnt, and moves the block to PARITY.
- PARITY:
  - ival & !isop: the word is dropped (no oval); wcnt++.
  - After the word with wcnt = pWORDS_N-1, return to HUNT.
- Early sop: ival & isop in PAYLOAD or PARITY.
  - Pulse ofrm_err on the output cycle.
  - Restart at word 0: forward the word with osop=1 and go to PAYLOAD.
  - A frame truncated in PAYLOAD never produces oeop and does not increment ofrm_cnt.
  - A frame truncated in PARITY already counted its oeop, but still pulses ofrm_err.
- pDATA_N=1 edge case: the sop word carries both osop=1 and oeop=1.
- Statistics:
  - On idecval, add the zero-extended idecerr, isymerr and ibiterr to their respective counters.
  - Every counter saturates at all-ones and never wraps.
  - iclr_stat has priority. If iclr_stat & idecval occur together, each counter loads the incoming value (counters clear, then the sample is applied). ofrm_cnt loads 1 if oeop is issued in that same cycle, otherwise 0.

## Timing
- Latency: oval/osop/oeop/odat/ofrm_err are registered, appearing 1 enabled cycle after the input word.
- Statistics counters update 1 cycle after idecval / iclr_stat.
- oval is a one-cycle strobe per forwarded word. osop, oeop and ofrm_err are 0 whenever oval is 0, except that ofrm_err coincides with the restarted osop word.
- odat holds its last value when oval=0.
- Reset (ireset=0 at a clock edge, regardless of iclkena):
  - State HUNT, wcnt=0.
  - oval, osop, oeop and ofrm_err = 0; odat = 0.
  - All counters = 0.
  - Reset mid-frame abandons the frame with no eop and no error pulse. Words before the next sop are discarded.
- No backpressure: the downstream block must accept a word on every oval.

## Test plan
- Clean frame: 255 contiguous words with word i = i, isop on i=0. Expect 239 oval cycles with odat 0..238, each 1 cycle after input; osop with odat=0; oeop with odat=238; no output for words 239..254; ofrm_cnt=1.
- Gapped frame: same frame with ival=0 inserted after every 3rd word, plus iclkena=0 for 5 cycles mid-frame. Expect identical output sequence and ofrm_cnt=1.
- Hunt and truncation:
  - 20 words without isop after reset: expect no oval.
  - Then sop, 100 words, then a new sop: expect ofrm_err=1 together with osop; ofrm_cnt=0.
  - Then the new frame completes: ofrm_cnt=1.
- Statistics accumulation: idecval 3 times with idecerr=2, isymerr=10, ibiterr=15. Expect ouncorr_cnt=6, osymerr_cnt=30, obiterr_cnt=45. Then iclr_stat with simultaneous idecval (1,4,7): expect 1, 4, 7.
- Saturation (pSTAT_W=8): idecval with ibiterr=1023 once. Expect obiterr_cnt=255, which stays at 255 after further strobes.
- Reset mid-frame: ireset=0 for 1 cycle at payload word 50, then frame continues without sop. Expect outputs 0 the following cycle, no further oval until the next isop, and counters 0.
